// File: rtl/midi_pkg.sv
// Shared types, status-byte constants and message-length decode for the MIDI transmit path.
package midi_pkg;

  typedef enum logic [1:0] {IDLE, S_STAT, S_D1, S_D2} tx_state_t;

  localparam logic [7:0] ST_NOTE_OFF = 8'h80;
  localparam logic [7:0] ST_NOTE_ON  = 8'h90;
  localparam logic [7:0] ST_POLY_AT  = 8'hA0;
  localparam logic [7:0] ST_CTRL     = 8'hB0;
  localparam logic [7:0] ST_PROG     = 8'hC0;
  localparam logic [7:0] ST_CHAN_AT  = 8'hD0;
  localparam logic [7:0] ST_PITCH    = 8'hE0;
  localparam logic [7:0] ST_SYSEX    = 8'hF0;
  localparam logic [7:0] ST_RT_MIN   = 8'hF8;

  // Total bytes in a message, status included; SysEx payload is never carried.
  function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd1;
    case ({status[7:4], 4'h0})
      ST_NOTE_OFF, ST_NOTE_ON, ST_POLY_AT, ST_CTRL, ST_PITCH: len = 2'd3;
      ST_PROG, ST_CHAN_AT: len = 2'd2;
      default: begin
        if (status == 8'hF2) len = 2'd3;
        else if ((status == 8'hF1) || (status == 8'hF3)) len = 2'd2;
      end
    endcase
    return len;
  endfunction

endpackage

// File: rtl/midi_out_mux_if.sv
// Message input and the two byte-sink handshakes of the MIDI transmit mux.
interface midi_out_mux_if;
  logic [4:0] cur_midi_ch;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] msg_status;
  logic [7:0] msg_data1;
  logic [7:0] msg_data2;
  logic       msg_err;
  logic [7:0] u_byte;
  logic       u_valid;
  logic       u_ready;
  logic [7:0] u_midibyte_nr;
  logic [7:0] c_byte;
  logic       c_valid;
  logic       c_ready;
  logic [7:0] c_midibyte_nr;
  logic       busy;

  modport master (
    output cur_midi_ch, msg_valid, msg_status, msg_data1, msg_data2, u_ready, c_ready,
    input  msg_ready, msg_err, u_byte, u_valid, u_midibyte_nr,
           c_byte, c_valid, c_midibyte_nr, busy
  );

  modport slave (
    input  cur_midi_ch, msg_valid, msg_status, msg_data1, msg_data2, u_ready, c_ready,
    output msg_ready, msg_err, u_byte, u_valid, u_midibyte_nr,
           c_byte, c_valid, c_midibyte_nr, busy
  );
endinterface

// File: rtl/midi_rs_tracker.sv
// Per-sink running-status memory: last channel status sent and consecutive-elision count.
module midi_rs_tracker
  import midi_pkg::*;
#(
  parameter int unsigned RUNNING_STATUS = 1,
  parameter int unsigned RS_REFRESH     = 8
) (
  input  logic       reg_clk,
  input  logic       reset_reg_N,
  input  logic [7:0] status,
  input  logic       send_done,
  input  logic       is_chan,
  input  logic       is_syscom,
  output logic       elide
);
  localparam int unsigned CNT_W = 8;

  logic [7:0]       last_st;
  logic [CNT_W-1:0] cnt;

  assign elide = (RUNNING_STATUS != 0) && is_chan && (status == last_st) &&
                 ((RS_REFRESH == 0) || (32'(cnt) < RS_REFRESH));

  // Committed when a message for this sink is accepted; realtime leaves state untouched.
  always_ff @(posedge reg_clk) begin
    if (!reset_reg_N) begin
      last_st <= 8'h00;
      cnt     <= '0;
    end else if (send_done) begin
      if (elide) begin
        if (RS_REFRESH != 0) cnt <= cnt + CNT_W'(1);
      end else if (is_chan) begin
        last_st <= status;
        cnt     <= '0;
      end else if (is_syscom) begin
        last_st <= 8'h00;
        cnt     <= '0;
      end
    end
  end

endmodule

// File: rtl/midi_out_mux.sv
// Serialises complete MIDI messages onto the UART or USB/CPU byte sink with optional running status.
module midi_out_mux
  import midi_pkg::*;
#(
  parameter int unsigned RUNNING_STATUS = 1,
  parameter int unsigned RS_REFRESH     = 8
) (
  input logic           reg_clk,
  input logic           reset_reg_N,
  midi_out_mux_if.slave bus
);
  tx_state_t  state;
  logic       sel;
  logic [1:0] len;
  logic [7:0] d1, d2;
  logic       msg_ready_q, msg_err_q, busy_q;
  logic       u_valid_q, c_valid_q;
  logic [7:0] u_byte_q, u_nr_q, c_byte_q, c_nr_q;

  logic [7:0] in_st_c;
  logic       in_sel_c, acc_c, acc_ok_c, is_chan_c, is_syscom_c;
  logic       elide_uart_c, elide_usb_c, elide_c, xfer_c, last_c;
  logic [7:0] first_byte_c, first_nr_c, next_byte_c, next_nr_c;
  tx_state_t  first_state_c, next_state_c;

  assign in_st_c     = bus.msg_status;
  assign in_sel_c    = bus.cur_midi_ch[4];
  assign acc_c       = bus.msg_valid & msg_ready_q;
  assign acc_ok_c    = acc_c & in_st_c[7];
  assign is_chan_c   = (in_st_c >= ST_NOTE_OFF) && (in_st_c < ST_SYSEX);
  assign is_syscom_c = (in_st_c >= ST_SYSEX) && (in_st_c < ST_RT_MIN);

  midi_rs_tracker #(.RUNNING_STATUS(RUNNING_STATUS), .RS_REFRESH(RS_REFRESH)) u_rs (
    .reg_clk     (reg_clk),
    .reset_reg_N (reset_reg_N),
    .status      (in_st_c),
    .send_done   (acc_ok_c & ~in_sel_c),
    .is_chan     (is_chan_c),
    .is_syscom   (is_syscom_c),
    .elide       (elide_uart_c)
  );

  midi_rs_tracker #(.RUNNING_STATUS(RUNNING_STATUS), .RS_REFRESH(RS_REFRESH)) c_rs (
    .reg_clk     (reg_clk),
    .reset_reg_N (reset_reg_N),
    .status      (in_st_c),
    .send_done   (acc_ok_c & in_sel_c),
    .is_chan     (is_chan_c),
    .is_syscom   (is_syscom_c),
    .elide       (elide_usb_c)
  );

  // First byte is decided at accept; an elided message starts at its first data byte.
  assign elide_c       = in_sel_c ? elide_usb_c : elide_uart_c;
  assign first_state_c = elide_c ? S_D1 : S_STAT;
  assign first_byte_c  = elide_c ? {1'b0, bus.msg_data1[6:0]} : in_st_c;
  assign first_nr_c    = elide_c ? 8'd1 : 8'd0;

  assign xfer_c       = sel ? (c_valid_q & bus.c_ready) : (u_valid_q & bus.u_ready);
  assign last_c       = (state == S_D2) || ((state == S_D1) && (len == 2'd2)) ||
                        ((state == S_STAT) && (len == 2'd1));
  assign next_state_c = (state == S_STAT) ? S_D1 : S_D2;
  assign next_byte_c  = (state == S_STAT) ? d1 : d2;
  assign next_nr_c    = (state == S_STAT) ? 8'd1 : 8'd2;

  always_ff @(posedge reg_clk) begin
    if (!reset_reg_N) begin
      state       <= IDLE;
      sel         <= 1'b0;
      len         <= 2'd0;
      d1          <= 8'h00;
      d2          <= 8'h00;
      msg_ready_q <= 1'b1;
      msg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      u_valid_q   <= 1'b0;
      u_byte_q    <= 8'h00;
      u_nr_q      <= 8'h00;
      c_valid_q   <= 1'b0;
      c_byte_q    <= 8'h00;
      c_nr_q      <= 8'h00;
    end else begin
      msg_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (acc_c) begin
            if (!in_st_c[7]) begin
              msg_err_q <= 1'b1;
            end else begin
              sel         <= in_sel_c;
              len         <= midi_msg_len(in_st_c);
              d1          <= {1'b0, bus.msg_data1[6:0]};
              d2          <= {1'b0, bus.msg_data2[6:0]};
              msg_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              state       <= first_state_c;
              if (in_sel_c) begin
                c_valid_q <= 1'b1;
                c_byte_q  <= first_byte_c;
                c_nr_q    <= first_nr_c;
              end else begin
                u_valid_q <= 1'b1;
                u_byte_q  <= first_byte_c;
                u_nr_q    <= first_nr_c;
              end
            end
          end
        end
        default: begin
          if (xfer_c) begin
            if (last_c) begin
              state       <= IDLE;
              msg_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              u_valid_q   <= 1'b0;
              c_valid_q   <= 1'b0;
            end else begin
              state <= next_state_c;
              if (sel) begin
                c_byte_q <= next_byte_c;
                c_nr_q   <= next_nr_c;
              end else begin
                u_byte_q <= next_byte_c;
                u_nr_q   <= next_nr_c;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.msg_ready     = msg_ready_q;
  assign bus.msg_err       = msg_err_q;
  assign bus.busy          = busy_q;
  assign bus.u_valid       = u_valid_q;
  assign bus.u_byte        = u_byte_q;
  assign bus.u_midibyte_nr = u_nr_q;
  assign bus.c_valid       = c_valid_q;
  assign bus.c_byte        = c_byte_q;
  assign bus.c_midibyte_nr = c_nr_q;

endmodule
